// File: rtl/dest_track_if.sv
// Bundles the ID-stage destination/source fields and the published
// destination-tracking outputs into one port.
// Ports: ID fields and Flush flow master->slave; EX/MEM/WB dests, labels,
//        WB write enable, Stall and StallCount flow slave->master.
interface dest_track_if #(
   parameter int AW     = 5,
   parameter int SCNT_W = 16
);
   logic [AW-1:0]     IDrs;
   logic [AW-1:0]     IDrt;
   logic              IDuseRt;
   logic [AW-1:0]     IDRDaddr;
   logic              IDRegWrite;
   logic              IDMemRead;
   logic              IDLabel;
   logic              Flush;

   logic [AW-1:0]     EXRDaddr;
   logic [AW-1:0]     MemRDaddr;
   logic [AW-1:0]     RDaddr;
   logic              WBRegWrite;
   logic              MemLabel;
   logic              WBLabel;
   logic              Stall;
   logic [SCNT_W-1:0] StallCount;

   modport master (
      output IDrs, IDrt, IDuseRt, IDRDaddr, IDRegWrite, IDMemRead, IDLabel, Flush,
      input  EXRDaddr, MemRDaddr, RDaddr, WBRegWrite, MemLabel, WBLabel,
             Stall, StallCount
   );

   modport slave (
      input  IDrs, IDrt, IDuseRt, IDRDaddr, IDRegWrite, IDMemRead, IDLabel, Flush,
      output EXRDaddr, MemRDaddr, RDaddr, WBRegWrite, MemLabel, WBLabel,
             Stall, StallCount
   );
endinterface

// File: rtl/dest_track_pipe.sv
// Carries {rd, we, ld, lab} of each in-flight instruction through EX, MEM, WB
// and raises the one-cycle load-use interlock; outputs are registered except
// Stall, which is combinational from EX state and the ID fields.
// Ports: clk, reset (async, active-low), io (dest_track_if.slave).
module dest_track_pipe #(
   parameter int AW     = 5,
   parameter int SCNT_W = 16
) (
   input  logic       clk,
   input  logic       reset,
   dest_track_if.slave io
);

   typedef struct packed {
      logic [AW-1:0] rd;
      logic          we;
      logic          ld;
      logic          lab;
   } stage_t;

   stage_t            ex_q;
   stage_t            mem_q;
   stage_t            wb_q;
   stage_t            id_stage;
   logic [SCNT_W-1:0] cnt_q;
   logic              hazard;
   logic              stall;

   assign id_stage = '{rd: io.IDRDaddr, we: io.IDRegWrite, ld: io.IDMemRead, lab: io.IDLabel};

   // A load to r0 never produces a value, so it cannot create a hazard.
   assign hazard = ex_q.we && ex_q.ld && (ex_q.rd != '0) &&
                   ((io.IDrs == ex_q.rd) || (io.IDuseRt && (io.IDrt == ex_q.rd)));

   // A squashed ID instruction consumes nothing, so flush overrides the stall.
   assign stall = hazard && !io.Flush;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
         cnt_q <= '0;
      end else begin
         wb_q  <= mem_q;
         mem_q <= ex_q;
         ex_q  <= (stall || io.Flush) ? stage_t'('0) : id_stage;
         if (stall && (cnt_q != {SCNT_W{1'b1}}))
            cnt_q <= cnt_q + 1'b1;
      end
   end

   // Non-writing stages publish 0 so the bypass compare falls back to the
   // register file.
   assign io.EXRDaddr   = ex_q.we  ? ex_q.rd  : '0;
   assign io.MemRDaddr  = mem_q.we ? mem_q.rd : '0;
   assign io.RDaddr     = wb_q.we  ? wb_q.rd  : '0;
   assign io.WBRegWrite = wb_q.we && (wb_q.rd != '0);
   assign io.MemLabel   = mem_q.lab;
   assign io.WBLabel    = wb_q.lab;
   assign io.Stall      = stall;
   assign io.StallCount = cnt_q;

endmodule
